// File: rtl/onchip_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_arb_pkg
// Brief    : Shared types and constants for the two-master RAM arbiter.
// Revision : 1.0
// ============================================================================
package onchip_mem_arb_pkg;

    typedef logic mst_idx_t;

    localparam mst_idx_t M0 = 1'b0;
    localparam mst_idx_t M1 = 1'b1;

    localparam int HOLD_W = 4;

    localparam int CMD_ADDR_W = 15;
    localparam int CMD_DATA_W = 32;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0]   address;
        logic [CMD_DATA_W/8-1:0] byteenable;
        logic                    read;
        logic                    write;
        logic [CMD_DATA_W-1:0]   writedata;
    } avmm_cmd_t;

endpackage
`default_nettype wire

// File: rtl/onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_arbiter_if
// Brief    : Avalon-MM master port bundle (command + read response).
// Revision : 1.0
// ============================================================================
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant2
// Brief    : Two-way grant with bounded round-robin hold or fixed m0 priority.
// Revision : 1.0
// ============================================================================
module rr_grant2
    import onchip_mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_HOLD   = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0_i,
    input  logic req1_i,
    output logic grant0_o,
    output logic grant1_o
);

    mst_idx_t          last_grant_q, last_grant_d;
    logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
    mst_idx_t          w_winner;
    logic              w_any_req;
    logic              w_keep;

    assign w_any_req = req0_i | req1_i;

    // A zero hold count means no history, so the previous owner cannot keep the bus.
    always_comb begin
        w_winner = M0;
        w_keep   = 1'b0;
        if (req0_i && req1_i) begin
            if (FIXED_PRIO != 0) begin
                w_winner = M0;
            end else begin
                w_keep   = (hold_cnt_q != '0) && (hold_cnt_q < HOLD_W'(MAX_HOLD));
                w_winner = w_keep ? last_grant_q : ~last_grant_q;
            end
        end else if (req1_i) begin
            w_winner = M1;
        end
    end

    assign grant0_o = w_any_req & (w_winner == M0);
    assign grant1_o = w_any_req & (w_winner == M1);

    always_comb begin
        last_grant_d = last_grant_q;
        hold_cnt_d   = '0;
        if (w_any_req) begin
            last_grant_d = w_winner;
            if (w_winner != last_grant_q) begin
                hold_cnt_d = HOLD_W'(1);
            end else if (hold_cnt_q != '1) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_q <= M1;
            hold_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_arbiter
// Brief    : Shares one 1-cycle-latency RAM between two Avalon-MM masters.
// Revision : 1.0
// ============================================================================
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_HOLD   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    onchip_mem_arbiter_if.slave  m0,
    onchip_mem_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W/8-1:0]  mem_byteenable,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [DATA_W-1:0]    mem_writedata,
    output logic                 mem_clken,
    input  logic [DATA_W-1:0]    mem_readdata
);

    logic     armed_q;
    logic     rd_pend_q, rd_pend_d;
    mst_idx_t rd_tag_q,  rd_tag_d;
    logic     w_live;
    logic     w_req0, w_req1;
    logic     w_grant0, w_grant1;
    logic     w_gnt_read;
    logic     w_rdv0, w_rdv1;

    // Nothing is granted while in reset or during the first cycle after release.
    assign w_live = armed_q & reset_n;
    assign w_req0 = w_live & (m0.read | m0.write);
    assign w_req1 = w_live & (m1.read | m1.write);

    rr_grant2 #(
        .FIXED_PRIO (FIXED_PRIO),
        .MAX_HOLD   (MAX_HOLD)
    ) u_grant (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0_i   (w_req0),
        .req1_i   (w_req1),
        .grant0_o (w_grant0),
        .grant1_o (w_grant1)
    );

    assign m0.waitrequest = ~w_grant0;
    assign m1.waitrequest = ~w_grant1;
    assign mem_clken      = w_live;
    assign mem_chipselect = w_grant0 | w_grant1;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        w_gnt_read     = 1'b0;
        if (w_grant0) begin
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_write      = m0.write;
            mem_writedata  = m0.writedata;
            w_gnt_read     = m0.read;
        end else if (w_grant1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_write      = m1.write;
            mem_writedata  = m1.writedata;
            w_gnt_read     = m1.read;
        end
    end

    // A simultaneous read+write is treated as a write and expects no response.
    always_comb begin
        rd_pend_d = mem_chipselect & w_gnt_read & ~mem_write;
        rd_tag_d  = rd_tag_q;
        if (rd_pend_d) begin
            rd_tag_d = w_grant1 ? M1 : M0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            armed_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= M0;
        end else begin
            armed_q   <= 1'b1;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    assign w_rdv0 = reset_n & rd_pend_q & (rd_tag_q == M0);
    assign w_rdv1 = reset_n & rd_pend_q & (rd_tag_q == M1);

    assign m0.readdatavalid = w_rdv0;
    assign m1.readdatavalid = w_rdv1;
    assign m0.readdata      = w_rdv0 ? mem_readdata : '0;
    assign m1.readdata      = w_rdv1 ? mem_readdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_mem_arbiter
// Brief    : Directed self-checking bench for the round-robin and fixed-priority arbiter.
// Revision : 1.0
// ============================================================================
module tb_onchip_mem_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) f0_if ();
    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) f1_if ();

    logic [ADDR_W-1:0] mem_address,   f_mem_address;
    logic [BE_W-1:0]   mem_byteenable, f_mem_byteenable;
    logic              mem_chipselect, f_mem_chipselect;
    logic              mem_write,      f_mem_write;
    logic [DATA_W-1:0] mem_writedata,  f_mem_writedata;
    logic              mem_clken,      f_mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] f_mem_readdata;

    assign f_mem_readdata = '0;

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(0), .MAX_HOLD(4)) dut (
        .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PRIO(1), .MAX_HOLD(4)) dut_fp (
        .clk(clk), .reset_n(reset_n), .m0(f0_if), .m1(f1_if),
        .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable),
        .mem_chipselect(f_mem_chipselect), .mem_write(f_mem_write),
        .mem_writedata(f_mem_writedata), .mem_clken(f_mem_clken),
        .mem_readdata(f_mem_readdata)
    );

    // RAM model: unwritten words read back as A000_0000 | address.
    logic [DATA_W-1:0] ram    [0:(1<<ADDR_W)-1];
    bit                ram_ok [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
        return 32'hA000_0000 | {17'd0, a};
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        return ram_ok[a] ? ram[a] : dflt(a);
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                ram[mem_address]    <= merge(rd_word(mem_address), mem_writedata, mem_byteenable);
                ram_ok[mem_address] <= 1'b1;
            end else begin
                mem_readdata <= rd_word(mem_address);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_if.read = 1'b0; m0_if.write = 1'b0;
        m1_if.read = 1'b0; m1_if.write = 1'b0;
        f0_if.read = 1'b0; f0_if.write = 1'b0;
        f1_if.read = 1'b0; f1_if.write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_if.read = 1'b1; m0_if.address = 15'h0040;
        m1_if.read = 1'b1; m1_if.address = 15'h0041;
        repeat (3) begin
            tick();
            total++;
            if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin
                bad++; $display("FAIL reset_wait: got m0=%b m1=%b want 1 1", m0_if.waitrequest, m1_if.waitrequest);
            end
            total++;
            if (mem_chipselect !== 1'b0 || mem_clken !== 1'b0) begin
                bad++; $display("FAIL reset_mem: got cs=%b clken=%b want 0 0", mem_chipselect, mem_clken);
            end
            total++;
            if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
                bad++; $display("FAIL reset_rdv: got m0=%b m1=%b want 0 0", m0_if.readdatavalid, m1_if.readdatavalid);
            end
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin
            bad++; $display("FAIL release_arm: got w0=%b w1=%b cs=%b want 1 1 0", m0_if.waitrequest, m1_if.waitrequest, mem_chipselect);
        end
        tick(); #1;
        total++;
        if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1 || mem_address !== 15'h0040 || mem_clken !== 1'b1) begin
            bad++; $display("FAIL first_conflict: got w0=%b w1=%b addr=%h clken=%b want 0 1 0040 1", m0_if.waitrequest, m1_if.waitrequest, mem_address, mem_clken);
        end
        tick();
        m0_if.read = 1'b0;
        #1;
        total++;
        if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hA000_0040) begin
            bad++; $display("FAIL reset_m0_ret: got v=%b d=%h want 1 a0000040", m0_if.readdatavalid, m0_if.readdata);
        end
        total++;
        if (m1_if.waitrequest !== 1'b0 || mem_address !== 15'h0041) begin
            bad++; $display("FAIL reset_m1_grant: got w1=%b addr=%h want 0 0041", m1_if.waitrequest, mem_address);
        end
        tick();
        m1_if.read = 1'b0;
        #1;
        total++;
        if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'hA000_0041 || m0_if.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL reset_m1_ret: got v1=%b d1=%h v0=%b want 1 a0000041 0", m1_if.readdatavalid, m1_if.readdata, m0_if.readdatavalid);
        end
    endtask

    task automatic test_byte_lanes();
        tick();
        m0_if.write = 1'b1; m0_if.address = 15'd5; m0_if.writedata = 32'h1122_3344; m0_if.byteenable = 4'b1111;
        #1;
        total++;
        if (m0_if.waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_writedata !== 32'h1122_3344 || mem_address !== 15'd5) begin
            bad++; $display("FAIL bl_write1: got w=%b we=%b wd=%h a=%h want 0 1 11223344 0005", m0_if.waitrequest, mem_write, mem_writedata, mem_address);
        end
        tick();
        m0_if.writedata = 32'hAABB_CCDD; m0_if.byteenable = 4'b0101;
        #1;
        total++;
        if (m0_if.waitrequest !== 1'b0 || mem_byteenable !== 4'b0101) begin
            bad++; $display("FAIL bl_write2: got w=%b be=%b want 0 0101", m0_if.waitrequest, mem_byteenable);
        end
        tick();
        m0_if.write = 1'b0; m0_if.read = 1'b1; m0_if.byteenable = 4'b1111;
        #1;
        total++;
        if (m0_if.waitrequest !== 1'b0 || mem_write !== 1'b0 || mem_chipselect !== 1'b1) begin
            bad++; $display("FAIL bl_read_cmd: got w=%b we=%b cs=%b want 0 0 1", m0_if.waitrequest, mem_write, mem_chipselect);
        end
        tick();
        m0_if.read = 1'b0;
        #1;
        total++;
        if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'h11BB_33DD) begin
            bad++; $display("FAIL bl_readback: got v=%b d=%h want 1 11bb33dd", m0_if.readdatavalid, m0_if.readdata);
        end
    endtask

    task automatic test_single();
        tick();
        m1_if.write = 1'b1; m1_if.address = 15'h0010; m1_if.writedata = 32'hDEAD_BEEF; m1_if.byteenable = 4'b1111;
        #1;
        total++;
        if (m1_if.waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_address !== 15'h0010 || mem_byteenable !== 4'b1111) begin
            bad++; $display("FAIL single_write: got w=%b we=%b a=%h be=%b want 0 1 0010 1111", m1_if.waitrequest, mem_write, mem_address, mem_byteenable);
        end
        tick();
        m1_if.write = 1'b0; m1_if.read = 1'b1;
        #1;
        total++;
        if (m1_if.waitrequest !== 1'b0 || mem_write !== 1'b0 || mem_chipselect !== 1'b1) begin
            bad++; $display("FAIL single_read_cmd: got w=%b we=%b cs=%b want 0 0 1", m1_if.waitrequest, mem_write, mem_chipselect);
        end
        total++;
        if (m1_if.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL single_early_rdv: got %b want 0", m1_if.readdatavalid);
        end
        tick();
        m1_if.read = 1'b0;
        #1;
        total++;
        if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single_return: got v=%b d=%h want 1 deadbeef", m1_if.readdatavalid, m1_if.readdata);
        end
        total++;
        if (m0_if.readdatavalid !== 1'b0 || m0_if.readdata !== 32'h0) begin
            bad++; $display("FAIL single_no_leak: got v0=%b d0=%h want 0 00000000", m0_if.readdatavalid, m0_if.readdata);
        end
    endtask

    task automatic test_contention();
        int n0 = 0;
        int n1 = 0;
        logic              prev_m = 1'b0;
        logic [ADDR_W-1:0] prev_a = '0;
        logic              exp_m;
        logic [ADDR_W-1:0] exp_a;
        for (int k = 0; k < 16; k++) begin
            tick();
            m0_if.read = 1'b1; m0_if.address = ADDR_W'(32'h100 + n0);
            m1_if.read = 1'b1; m1_if.address = ADDR_W'(32'h200 + n1);
            #1;
            exp_m = ((k / 4) % 2) == 1;
            exp_a = exp_m ? ADDR_W'(32'h200 + n1) : ADDR_W'(32'h100 + n0);
            total++;
            if (m0_if.waitrequest !== exp_m || m1_if.waitrequest !== !exp_m || mem_chipselect !== 1'b1 || mem_address !== exp_a) begin
                bad++; $display("FAIL rr_grant[%0d]: got w0=%b w1=%b cs=%b a=%h want %b %b 1 %h", k, m0_if.waitrequest, m1_if.waitrequest, mem_chipselect, mem_address, exp_m, !exp_m, exp_a);
            end
            if (k > 0) begin
                total++;
                if (prev_m ? (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== dflt(prev_a) || m0_if.readdatavalid !== 1'b0)
                           : (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== dflt(prev_a) || m1_if.readdatavalid !== 1'b0)) begin
                    bad++; $display("FAIL rr_return[%0d]: got v0=%b d0=%h v1=%b d1=%h want master %0d data %h", k, m0_if.readdatavalid, m0_if.readdata, m1_if.readdatavalid, m1_if.readdata, prev_m, dflt(prev_a));
                end
            end
            prev_m = exp_m;
            prev_a = exp_a;
            if (exp_m) n1++; else n0++;
        end
        tick();
        idle_all();
        #1;
        total++;
        if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== dflt(prev_a)) begin
            bad++; $display("FAIL rr_last_return: got v1=%b d1=%h want 1 %h", m1_if.readdatavalid, m1_if.readdata, dflt(prev_a));
        end
    endtask

    task automatic test_fixed_prio();
        for (int k = 0; k < 10; k++) begin
            tick();
            f0_if.read = 1'b1; f0_if.address = 15'h0001;
            f1_if.read = 1'b1; f1_if.address = 15'h0002;
            #1;
            total++;
            if (f0_if.waitrequest !== 1'b0 || f1_if.waitrequest !== 1'b1) begin
                bad++; $display("FAIL fp_hold[%0d]: got w0=%b w1=%b want 0 1", k, f0_if.waitrequest, f1_if.waitrequest);
            end
        end
        tick();
        f0_if.read = 1'b0;
        #1;
        total++;
        if (f1_if.waitrequest !== 1'b0 || f_mem_address !== 15'h0002) begin
            bad++; $display("FAIL fp_release: got w1=%b a=%h want 0 0002", f1_if.waitrequest, f_mem_address);
        end
        tick();
        f1_if.read = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        tick();
        m0_if.read = 1'b1; m0_if.address = 15'h0030;
        #1;
        total++;
        if (m0_if.waitrequest !== 1'b0) begin
            bad++; $display("FAIL mid_grant: got w0=%b want 0", m0_if.waitrequest);
        end
        tick();
        reset_n = 1'b0;
        m0_if.address = 15'h0031;
        m1_if.read = 1'b1; m1_if.address = 15'h0032;
        #1;
        total++;
        if (m0_if.readdatavalid !== 1'b0 || m0_if.readdata !== 32'h0) begin
            bad++; $display("FAIL mid_drop: got v0=%b d0=%h want 0 00000000", m0_if.readdatavalid, m0_if.readdata);
        end
        repeat (2) begin
            tick();
            total++;
            if (m0_if.readdatavalid !== 1'b0 || m0_if.waitrequest !== 1'b1) begin
                bad++; $display("FAIL mid_in_reset: got v0=%b w0=%b want 0 1", m0_if.readdatavalid, m0_if.waitrequest);
            end
        end
        tick();
        reset_n = 1'b1;
        #1;
        total++;
        if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1 || m0_if.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL mid_rearm: got w0=%b w1=%b v0=%b want 1 1 0", m0_if.waitrequest, m1_if.waitrequest, m0_if.readdatavalid);
        end
        tick(); #1;
        total++;
        if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1 || m0_if.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL mid_conflict: got w0=%b w1=%b v0=%b want 0 1 0", m0_if.waitrequest, m1_if.waitrequest, m0_if.readdatavalid);
        end
        tick();
        m0_if.read = 1'b0;
        #1;
        total++;
        if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hA000_0031 || m1_if.waitrequest !== 1'b0) begin
            bad++; $display("FAIL mid_after: got v0=%b d0=%h w1=%b want 1 a0000031 0", m0_if.readdatavalid, m0_if.readdata, m1_if.waitrequest);
        end
        tick();
        m1_if.read = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_all();
        m0_if.address = '0; m0_if.byteenable = '0; m0_if.writedata = '0;
        m1_if.address = '0; m1_if.byteenable = '0; m1_if.writedata = '0;
        f0_if.address = '0; f0_if.byteenable = '0; f0_if.writedata = '0;
        f1_if.address = '0; f1_if.byteenable = '0; f1_if.writedata = '0;
        test_reset();
        test_byte_lanes();
        test_single();
        test_contention();
        test_fixed_prio();
        test_reset_mid_read();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares one single-port 32K x 32 on-chip RAM (1-cycle read latency, byte-enabled writes) between a CPU data master (m0) and an accelerator/DMA master (m1).
- Sits between the interconnect and the RAM slave port.
- Each cycle it grants at most one request and drives the RAM command.
- It tags each issued read and routes the returned data, with readdatavalid, back to the issuing master.

Parameters:
- ADDR_W, 15, word address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width; byteenable width = DATA_W/8
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins on conflict
- MAX_HOLD, 4, round-robin only: maximum consecutive grants to one master while the other is requesting (range 1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- mN_address  in  ADDR_W  word address (N = 0, 1)
- mN_byteenable  in  DATA_W/8  write byte lanes
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = command not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  readdata valid
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write enable
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable, tied high after reset
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after the read command

Behaviour:
- Requests:
  - reqN = mN_read | mN_write.
  - mN_read and mN_write both high is illegal; if it occurs, write wins.
- Grant (combinational, same cycle):
  - Only one master requesting: that master is granted.
  - Both requesting, FIXED_PRIO=1: m0 is granted.
  - Both requesting, round-robin: the master other than last_grant is granted, unless hold_cnt < MAX_HOLD and the last_grant master is still requesting. In that case last_grant keeps the grant.
- Waitrequest:
  - mN_waitrequest = ~(grantN).
  - Forced high while reset_n=0 and for the first cycle after reset release (registered armed flag).
  - Non-granted requesters must hold their command stable.
- mem_* outputs:
  - Driven by the granted master's fields; mem_chipselect = grant0 | grant1.
  - mem_write = granted master's write.
  - With no grant: mem_chipselect=0, mem_write=0, address/data/byteenable = 0.
- Read return:
  - A granted read sets rd_pend<=1 and rd_tag<=N at the clock edge.
  - Next cycle: mN_readdata = mem_readdata and mN_readdatavalid = rd_pend & (rd_tag==N).
  - Back-to-back reads are allowed, one per cycle (fully pipelined; single-entry tag register suffices).
- Writes:
  - Complete in the grant cycle; no response.
- State:
  - last_grant (1b) updates on every grant.
  - hold_cnt (4b): resets to 1 on a grant switch, increments on a repeated grant, saturates at 15.
  - hold_cnt is cleared on a cycle with no grant; that cycle clears the hold history.
- Readdata when not valid:
  - mN_readdata is 0 when its readdatavalid is low. This prevents data leaking between masters.
- Reset (reset_n=0 at clk edge):
  - last_grant=1 (so m0 wins the first conflict), hold_cnt=0, rd_pend=0, rd_tag=0, armed=0.
  - All outputs 0 except mN_waitrequest=1; mem_clken=0 during reset, 1 after.
- Reset mid-operation:
  - An in-flight read is dropped; no readdatavalid is issued after reset.
- Latency:
  - Uncontended read: request cycle T, readdatavalid at T+1.
  - Contended read: worst case MAX_HOLD cycles of waitrequest.

Decomposition:
- Package onchip_mem_arb_pkg:
  - master index type (1 bit) and constants M0=0, M1=1
  - HOLD_W=4
  - avalon command record type (address, byteenable, read, write, writedata)
- One sub-module, rr_grant2: 2-way grant logic with last_grant/hold_cnt registers and FIXED_PRIO/MAX_HOLD parameters.
- Muxing and the read-return tag stay in the top level.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with both masters requesting -> waitrequest=1 on both, mem_chipselect=0, no readdatavalid. One cycle after release both waitrequests are still 1; the following cycle m0 is granted.
- Single master: m1 writes 0xDEADBEEF, byteenable 4'b1111, to address 0x0010, then reads 0x0010 -> write granted with no wait. Read data 0xDEADBEEF appears on m1_readdata with m1_readdatavalid exactly 1 cycle after the read grant; m0_readdatavalid stays 0.
- Byte lanes: write 0x11223344 to address 5, then write 0xAABBCCDD with byteenable 4'b0101, then read -> 0x11BB33DD.
- Contention, FIXED_PRIO=0, MAX_HOLD=4: both masters issue continuous reads -> grants run m0 x4, m1 x4, alternating. Each readdatavalid routes to the correct master with its own address data; no grant gap.
- FIXED_PRIO=1: both masters request continuously for 10 cycles -> m0 granted all 10 cycles, m1_waitrequest=1 throughout. m1 is granted the first cycle m0 deasserts.
- Reset mid-read: assert reset_n=0 in the cycle after m0's read grant -> m0_readdatavalid never asserts; after re-arm, the first conflict is granted to m0.
